// File: rtl/ball_fall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ball_fall_ctrl_pkg
//   Shared definitions for the ball-fall game-flow controller.
//   - POS_W   : width of every screen coordinate (x and y) in pixels.
//   - state_t : controller state encoding. The numeric values are visible on
//               o_state and are relied on by the UI and debug tools, so they
//               must not be renumbered.
// -----------------------------------------------------------------------------
package ball_fall_ctrl_pkg;

  localparam int POS_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PLAYING      = 3'd1,
    ST_FALLING      = 3'd2,
    ST_RESPAWN_WAIT = 3'd3,
    ST_WON          = 3'd4,
    ST_GAME_OVER    = 3'd5
  } state_t;

endpackage

// File: rtl/ball_fall_ctrl_fall_step.sv
// -----------------------------------------------------------------------------
// fall_step
//   Combinational single-axis convergence step used while the ball sinks into
//   a hole. The ball moves a quarter of the remaining distance per frame,
//   with a minimum of one pixel so it always lands exactly on the hole centre.
//
// Ports:
//   hole  in  POS_W  hole centre on this axis
//   cur   in  POS_W  current ball coordinate on this axis
//   next  out POS_W  coordinate after one frame step
// -----------------------------------------------------------------------------
module fall_step
  import ball_fall_ctrl_pkg::*;
(
  input  logic [POS_W-1:0] hole,
  input  logic [POS_W-1:0] cur,
  output logic [POS_W-1:0] next
);

  localparam logic signed [POS_W:0] ONE     = (POS_W+1)'(1);
  localparam logic signed [POS_W:0] MIN_ONE = {(POS_W+1){1'b1}};

  logic signed [POS_W:0] diff;
  logic signed [POS_W:0] step;
  logic signed [POS_W:0] sum;

  always_comb begin
    diff = $signed({1'b0, hole}) - $signed({1'b0, cur});
    // Arithmetic shift floors toward -inf, so only small positive distances
    // (1..3) collapse to zero; those still need a one-pixel nudge.
    step = diff >>> 2;
    if ((diff != '0) && (step == '0)) begin
      step = diff[POS_W] ? MIN_ONE : ONE;
    end
    // |step| never exceeds |diff|, so the sum stays inside 0..2**POS_W-1.
    sum  = $signed({1'b0, cur}) + step;
    next = sum[POS_W-1:0];
  end

endmodule

// File: rtl/ball_fall_ctrl.sv
// -----------------------------------------------------------------------------
// ball_fall_ctrl
//   Game-flow controller sitting behind the hole-conflict detector. It gates
//   the detector/physics via o_is_game_playing, animates the ball sinking into
//   the hit hole (radius shrinks 1 px per frame while the centre converges on
//   the hole), then resolves win / lose-a-life-and-respawn / game over.
//
// Parameters:
//   RADIUS       full ball radius in pixels, also the fall length in frames
//   LIVES        lives loaded on (re)start, 1..3
//   HOLD_FRAMES  frames spent hidden before a respawn
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_frame_tick            one-cycle pulse per video frame
//   i_start                 start/restart request (IDLE, WON, GAME_OVER only)
//   i_win, i_fail           detector flags; win wins when both are high
//   i_pos_fall_x/y          centre of the hole that was hit
//   i_bl_x/y                live ball position from physics
//   i_bl_pos_initial_x/y    spawn position
//   o_is_game_playing       high in PLAYING only
//   o_ball_x/y              ball position for the renderer
//   o_ball_radius           drawn radius
//   o_ball_visible          renderer draws the ball
//   o_respawn               one-cycle pulse: physics reloads spawn position
//   o_lives                 remaining lives
//   o_game_won/o_game_over  high in WON / GAME_OVER
//   o_state                 state encoding (ball_fall_ctrl_pkg::state_t)
//
// Pulses: o_respawn is registered and high for exactly the first cycle spent
// in PLAYING; physics is expected to act on it at the following clock edge.
// -----------------------------------------------------------------------------
module ball_fall_ctrl
  import ball_fall_ctrl_pkg::*;
#(
  parameter int RADIUS      = 16,
  parameter int LIVES       = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_tick,
  input  logic             i_start,
  input  logic             i_win,
  input  logic             i_fail,
  input  logic [POS_W-1:0] i_pos_fall_x,
  input  logic [POS_W-1:0] i_pos_fall_y,
  input  logic [POS_W-1:0] i_bl_x,
  input  logic [POS_W-1:0] i_bl_y,
  input  logic [POS_W-1:0] i_bl_pos_initial_x,
  input  logic [POS_W-1:0] i_bl_pos_initial_y,
  output logic             o_is_game_playing,
  output logic [POS_W-1:0] o_ball_x,
  output logic [POS_W-1:0] o_ball_y,
  output logic [4:0]       o_ball_radius,
  output logic             o_ball_visible,
  output logic             o_respawn,
  output logic [1:0]       o_lives,
  output logic             o_game_won,
  output logic             o_game_over,
  output logic [2:0]       o_state
);

  localparam int                HOLD_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [4:0]        RADIUS_V  = 5'(RADIUS);
  localparam logic [1:0]        LIVES_V   = 2'(LIVES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t            state_q,   state_d;
  logic [1:0]        lives_q,   lives_d;
  logic [4:0]        radius_q,  radius_d;
  logic              visible_q, visible_d;
  logic              respawn_q, respawn_d;
  // guard_q marks the first cycle in PLAYING: the detector's registered flags
  // may still reflect the previous ball position, so they are not trusted yet.
  logic              guard_q,   guard_d;
  logic              kind_win_q, kind_win_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic [POS_W-1:0]  cur_x_q,   cur_x_d;
  logic [POS_W-1:0]  cur_y_q,   cur_y_d;
  logic [POS_W-1:0]  hole_x_q,  hole_x_d;
  logic [POS_W-1:0]  hole_y_q,  hole_y_d;

  logic [POS_W-1:0]  step_x;
  logic [POS_W-1:0]  step_y;

  fall_step u_step_x (
    .hole (hole_x_q),
    .cur  (cur_x_q),
    .next (step_x)
  );

  fall_step u_step_y (
    .hole (hole_y_q),
    .cur  (cur_y_q),
    .next (step_y)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      lives_q    <= LIVES_V;
      radius_q   <= RADIUS_V;
      visible_q  <= 1'b1;
      respawn_q  <= 1'b0;
      guard_q    <= 1'b0;
      kind_win_q <= 1'b0;
      hold_q     <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      hole_x_q   <= '0;
      hole_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      radius_q   <= radius_d;
      visible_q  <= visible_d;
      respawn_q  <= respawn_d;
      guard_q    <= guard_d;
      kind_win_q <= kind_win_d;
      hold_q     <= hold_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      hole_x_q   <= hole_x_d;
      hole_y_q   <= hole_y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    radius_d   = radius_q;
    visible_d  = visible_q;
    respawn_d  = 1'b0;
    guard_d    = 1'b0;
    kind_win_d = kind_win_q;
    hold_d     = hold_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    hole_x_d   = hole_x_q;
    hole_y_d   = hole_y_q;

    case (state_q)
      ST_IDLE, ST_WON, ST_GAME_OVER: begin
        if (i_start) begin
          lives_d   = LIVES_V;
          radius_d  = RADIUS_V;
          visible_d = 1'b1;
          respawn_d = 1'b1;
          guard_d   = 1'b1;
          state_d   = ST_PLAYING;
        end
      end

      ST_PLAYING: begin
        if (!guard_q && (i_win || i_fail)) begin
          hole_x_d   = i_pos_fall_x;
          hole_y_d   = i_pos_fall_y;
          cur_x_d    = i_bl_x;
          cur_y_d    = i_bl_y;
          kind_win_d = i_win;
          state_d    = ST_FALLING;
        end
      end

      ST_FALLING: begin
        if (i_frame_tick) begin
          radius_d = radius_q - 5'd1;
          cur_x_d  = step_x;
          cur_y_d  = step_y;
          // This tick takes the radius to zero: the ball has vanished.
          if (radius_q <= 5'd1) begin
            radius_d  = '0;
            visible_d = 1'b0;
            if (kind_win_q) begin
              state_d = ST_WON;
            end else if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              hold_d  = '0;
              state_d = ST_RESPAWN_WAIT;
            end else begin
              lives_d = '0;
              state_d = ST_GAME_OVER;
            end
          end
        end
      end

      ST_RESPAWN_WAIT: begin
        if (i_frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            radius_d  = RADIUS_V;
            visible_d = 1'b1;
            respawn_d = 1'b1;
            guard_d   = 1'b1;
            state_d   = ST_PLAYING;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_ball_x = cur_x_q;
    o_ball_y = cur_y_q;
    case (state_q)
      ST_IDLE: begin
        o_ball_x = i_bl_pos_initial_x;
        o_ball_y = i_bl_pos_initial_y;
      end
      ST_PLAYING: begin
        // Physics reloads the spawn point one edge after o_respawn, so the
        // guard cycle shows the spawn point directly.
        if (guard_q) begin
          o_ball_x = i_bl_pos_initial_x;
          o_ball_y = i_bl_pos_initial_y;
        end else begin
          o_ball_x = i_bl_x;
          o_ball_y = i_bl_y;
        end
      end
      default: begin
        o_ball_x = cur_x_q;
        o_ball_y = cur_y_q;
      end
    endcase
  end

  assign o_is_game_playing = (state_q == ST_PLAYING);
  assign o_ball_radius     = radius_q;
  assign o_ball_visible    = visible_q;
  assign o_respawn         = respawn_q;
  assign o_lives           = lives_q;
  assign o_game_won        = (state_q == ST_WON);
  assign o_game_over       = (state_q == ST_GAME_OVER);
  assign o_state           = state_q;

endmodule

// File: tb/tb_ball_fall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ball_fall_ctrl
//   Self-checking bench for ball_fall_ctrl. Fall trajectories come from an
//   arithmetic reference (floor of a quarter of the remaining distance, at
//   least one pixel) and are queued in exp_q, one entry per frame tick.
// -----------------------------------------------------------------------------
module tb_ball_fall_ctrl;

  localparam int RADIUS = 16;
  localparam int LIVES  = 3;
  localparam int HOLD   = 60;
  localparam logic [9:0] INIT_X = 10'd320;
  localparam logic [9:0] INIT_Y = 10'd400;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       win = 1'b0;
  logic       fail = 1'b0;
  logic [9:0] pos_fall_x = '0, pos_fall_y = '0;
  logic [9:0] bl_x = 10'd50, bl_y = 10'd60;
  logic [9:0] init_x = INIT_X, init_y = INIT_Y;

  logic       is_game_playing;
  logic [9:0] ball_x, ball_y;
  logic [4:0] ball_radius;
  logic       ball_visible;
  logic       respawn;
  logic [1:0] lives;
  logic       game_won;
  logic       game_over;
  logic [2:0] state;

  always #5 clk = ~clk;

  ball_fall_ctrl #(.RADIUS(RADIUS), .LIVES(LIVES), .HOLD_FRAMES(HOLD)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_frame_tick       (frame_tick),
    .i_start            (start),
    .i_win              (win),
    .i_fail             (fail),
    .i_pos_fall_x       (pos_fall_x),
    .i_pos_fall_y       (pos_fall_y),
    .i_bl_x             (bl_x),
    .i_bl_y             (bl_y),
    .i_bl_pos_initial_x (init_x),
    .i_bl_pos_initial_y (init_y),
    .o_is_game_playing  (is_game_playing),
    .o_ball_x           (ball_x),
    .o_ball_y           (ball_y),
    .o_ball_radius      (ball_radius),
    .o_ball_visible     (ball_visible),
    .o_respawn          (respawn),
    .o_lives            (lives),
    .o_game_won         (game_won),
    .o_game_over        (game_over),
    .o_state            (state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [19:0] exp_q[$];
  int err_cnt  = 0;
  int chk_cnt  = 0;
  int resp_cnt = 0;
  int exp_lives;

  // Respawn pulses counted mid-cycle, away from the active edge.
  always @(negedge clk) if (respawn) resp_cnt++;

  // ---------------------------------------------------------------------------
  // Reference model: one frame of convergence, floor(d/4) with 1 px minimum.
  // ---------------------------------------------------------------------------
  function automatic int conv(input int hole, input int cur);
    int d, s;
    d = hole - cur;
    s = (d >= 0) ? (d / 4) : -((3 - d) / 4);
    if (d != 0 && s == 0) s = (d > 0) ? 1 : -1;
    return cur + s;
  endfunction

  task automatic build_traj(input int bx, input int by, input int hx, input int hy);
    int x, y;
    exp_q.delete();
    x = bx;
    y = by;
    for (int i = 0; i < RADIUS; i++) begin
      x = conv(hx, x);
      y = conv(hy, y);
      exp_q.push_back({10'(x), 10'(y)});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Present a detector hit for one edge; the model trajectory is queued.
  task automatic trigger(input logic w, input logic f, input int bx, input int by,
                         input int hx, input int hy);
    bl_x = 10'(bx); bl_y = 10'(by);
    pos_fall_x = 10'(hx); pos_fall_y = 10'(hy);
    win = w; fail = f;
    build_traj(bx, by, hx, hy);
    cyc();
    win = 1'b0; fail = 1'b0;
  endtask

  // Sixteen frames of falling, checking position and radius after each one.
  task automatic fall_all(input string name);
    logic [19:0] e;
    for (int i = 0; i < RADIUS; i++) begin
      tick();
      e = exp_q.pop_front();
      chk_cnt++;
      if ({ball_x, ball_y} !== e)
        $display("FAIL %s_pos[%0d]: got (%0d,%0d) want (%0d,%0d)", name, i, ball_x, ball_y, e[19:10], e[9:0]);
      if ({ball_x, ball_y} !== e) err_cnt++;
      chk_cnt++;
      if (ball_radius !== 5'(RADIUS - 1 - i)) begin
        err_cnt++;
        $display("FAIL %s_radius[%0d]: got %0d want %0d", name, i, ball_radius, RADIUS - 1 - i);
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
    chk_cnt++;
    if (ball_visible !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_visible: got %0d want 0", name, ball_visible);
    end
  endtask

  // Hold phase of RESPAWN_WAIT: HOLD-1 ticks stay put, the last one respawns.
  task automatic hold_and_respawn(input string name);
    int r0;
    r0 = resp_cnt;
    repeat (HOLD - 1) tick();
    chk_cnt++;
    if (state !== 3'd3 || resp_cnt != r0) begin
      err_cnt++;
      $display("FAIL %s_hold: state %0d pulses %0d want state 3 pulses 0", name, state, resp_cnt - r0);
    end
    tick();
    chk_cnt++;
    if (state !== 3'd1 || respawn !== 1'b1 || {ball_x, ball_y} !== {INIT_X, INIT_Y} ||
        ball_radius !== 5'(RADIUS) || ball_visible !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_respawn: state %0d resp %0d pos (%0d,%0d) r %0d vis %0d want 1 1 (%0d,%0d) %0d 1",
               name, state, respawn, ball_x, ball_y, ball_radius, ball_visible, INIT_X, INIT_Y, RADIUS);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk_cnt++;
    if (state !== 3'd0 || lives !== 2'(LIVES) || ball_radius !== 5'(RADIUS) || ball_visible !== 1'b1 ||
        {ball_x, ball_y} !== {INIT_X, INIT_Y} || respawn !== 1'b0 || is_game_playing !== 1'b0 ||
        game_won !== 1'b0 || game_over !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_values: state %0d lives %0d r %0d vis %0d pos (%0d,%0d) resp %0d play %0d won %0d over %0d",
               state, lives, ball_radius, ball_visible, ball_x, ball_y, respawn, is_game_playing, game_won, game_over);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_start();
    int r0;
    r0 = resp_cnt;
    do_start();
    chk_cnt++;
    if (respawn !== 1'b1 || state !== 3'd1 || lives !== 2'(LIVES) || is_game_playing !== 1'b1 ||
        {ball_x, ball_y} !== {INIT_X, INIT_Y}) begin
      err_cnt++;
      $display("FAIL start_guard: resp %0d state %0d lives %0d play %0d pos (%0d,%0d)",
               respawn, state, lives, is_game_playing, ball_x, ball_y);
    end
    cyc();
    chk_cnt++;
    if (respawn !== 1'b0 || resp_cnt - r0 != 1) begin
      err_cnt++;
      $display("FAIL start_pulse: resp %0d pulses %0d want 0 and 1", respawn, resp_cnt - r0);
    end
    for (int i = 0; i < 4; i++) begin
      bl_x = 10'($urandom_range(0, 1023));
      bl_y = 10'($urandom_range(0, 1023));
      #1;
      chk_cnt++;
      if ({ball_x, ball_y} !== {bl_x, bl_y}) begin
        err_cnt++;
        $display("FAIL passthrough[%0d]: got (%0d,%0d) want (%0d,%0d)", i, ball_x, ball_y, bl_x, bl_y);
      end
    end
    // A start request while playing is ignored.
    r0 = resp_cnt;
    do_start();
    cyc();
    chk_cnt++;
    if (state !== 3'd1 || resp_cnt != r0) begin
      err_cnt++;
      $display("FAIL start_ignored: state %0d pulses %0d want 1 and 0", state, resp_cnt - r0);
    end
    exp_lives = LIVES;
  endtask

  task automatic test_fail_fall();
    trigger(1'b0, 1'b1, 100, 100, 108, 92);
    chk_cnt++;
    if (state !== 3'd2 || is_game_playing !== 1'b0 || {ball_x, ball_y} !== {10'd100, 10'd100} ||
        ball_radius !== 5'(RADIUS)) begin
      err_cnt++;
      $display("FAIL fail_enter: state %0d play %0d pos (%0d,%0d) r %0d want 2 0 (100,100) %0d",
               state, is_game_playing, ball_x, ball_y, ball_radius, RADIUS);
    end
    fall_all("fail_fall");
    exp_lives--;
    chk_cnt++;
    if ({ball_x, ball_y} !== {10'd108, 10'd92} || lives !== 2'(exp_lives) || state !== 3'd3) begin
      err_cnt++;
      $display("FAIL fail_end: pos (%0d,%0d) lives %0d state %0d want (108,92) %0d 3",
               ball_x, ball_y, lives, state, exp_lives);
    end
    hold_and_respawn("fail_fall");
    cyc();
  endtask

  task automatic test_win_priority();
    trigger(1'b1, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023),
            $urandom_range(0, 1023), $urandom_range(0, 1023));
    fall_all("win");
    chk_cnt++;
    if (state !== 3'd4 || game_won !== 1'b1 || game_over !== 1'b0 || lives !== 2'(exp_lives)) begin
      err_cnt++;
      $display("FAIL win_end: state %0d won %0d over %0d lives %0d want 4 1 0 %0d",
               state, game_won, game_over, lives, exp_lives);
    end
    repeat (5) tick();
    chk_cnt++;
    if (state !== 3'd4 || ball_visible !== 1'b0) begin
      err_cnt++;
      $display("FAIL win_hold: state %0d vis %0d want 4 0", state, ball_visible);
    end
    do_start();
    cyc();
    exp_lives = LIVES;
    chk_cnt++;
    if (state !== 3'd1 || lives !== 2'(exp_lives) || ball_visible !== 1'b1) begin
      err_cnt++;
      $display("FAIL win_restart: state %0d lives %0d vis %0d want 1 %0d 1", state, lives, ball_visible, exp_lives);
    end
  endtask

  task automatic test_game_over();
    int r0;
    for (int k = 0; k < LIVES; k++) begin
      trigger(1'b0, 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023));
      fall_all("over");
      exp_lives--;
      chk_cnt++;
      if (lives !== 2'(exp_lives) || state !== ((exp_lives > 0) ? 3'd3 : 3'd5)) begin
        err_cnt++;
        $display("FAIL over_lives[%0d]: lives %0d state %0d want %0d", k, lives, state, exp_lives);
      end
      if (exp_lives > 0) begin
        hold_and_respawn("over");
        cyc();
      end
    end
    chk_cnt++;
    if (game_over !== 1'b1 || game_won !== 1'b0) begin
      err_cnt++;
      $display("FAIL over_flag: over %0d won %0d want 1 0", game_over, game_won);
    end
    r0 = resp_cnt;
    do_start();
    cyc();
    exp_lives = LIVES;
    chk_cnt++;
    if (lives !== 2'(exp_lives) || state !== 3'd1 || resp_cnt - r0 != 1) begin
      err_cnt++;
      $display("FAIL over_restart: lives %0d state %0d pulses %0d want %0d 1 1", lives, state, resp_cnt - r0, exp_lives);
    end
  endtask

  task automatic test_fail_held_guard();
    trigger(1'b0, 1'b1, 200, 300, 210, 290);
    fall_all("held");
    exp_lives--;
    fail = 1'b1;
    hold_and_respawn("held");
    cyc();
    chk_cnt++;
    if (state !== 3'd1) begin
      err_cnt++;
      $display("FAIL held_guard: state %0d want 1", state);
    end
    cyc();
    chk_cnt++;
    if (state !== 3'd2) begin
      err_cnt++;
      $display("FAIL held_retrigger: state %0d want 2", state);
    end
    fail = 1'b0;
  endtask

  task automatic test_reset_mid_fall();
    int r0;
    repeat (RADIUS - 7) tick();
    chk_cnt++;
    if (ball_radius !== 5'd7 || state !== 3'd2) begin
      err_cnt++;
      $display("FAIL midfall_radius: r %0d state %0d want 7 2", ball_radius, state);
    end
    r0 = resp_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (state !== 3'd0 || ball_radius !== 5'(RADIUS) || lives !== 2'(LIVES) || respawn !== 1'b0 ||
        ball_visible !== 1'b1 || {ball_x, ball_y} !== {INIT_X, INIT_Y}) begin
      err_cnt++;
      $display("FAIL midfall_reset: state %0d r %0d lives %0d resp %0d vis %0d pos (%0d,%0d)",
               state, ball_radius, lives, respawn, ball_visible, ball_x, ball_y);
    end
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk_cnt++;
    if (state !== 3'd0 || resp_cnt != r0) begin
      err_cnt++;
      $display("FAIL midfall_after: state %0d pulses %0d want 0 0", state, resp_cnt - r0);
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_start();
    test_fail_fall();
    test_win_priority();
    test_game_over();
    test_fail_held_guard();
    test_reset_mid_fall();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
